// File: rtl/divider_stream.sv
// rtl/divider_stream.sv - pipelined restoring divider with valid/ready stream interface
module divider_stream #(
  parameter int DATA_LEN = 32,
  parameter int STAGES   = 8,
  parameter int TAG_W    = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [DATA_LEN-1:0] i_in_a,
  input  logic [DATA_LEN-1:0] i_in_b,
  input  logic                i_in_signed,
  input  logic [TAG_W-1:0]    i_in_tag,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [DATA_LEN-1:0] o_out_quot,
  output logic [DATA_LEN-1:0] o_out_rem,
  output logic [TAG_W-1:0]    o_out_tag,
  output logic                o_out_div_zero,
  output logic                o_out_overflow,
  output logic                o_busy
);

  localparam int STEPS = DATA_LEN / STAGES;
  localparam int LAST  = STAGES - 1;
  localparam logic [DATA_LEN-1:0] MIN_VAL = {1'b1, {(DATA_LEN-1){1'b0}}};

  logic                w_en;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [DATA_LEN-1:0] w_a_mag;
  logic [DATA_LEN-1:0] w_b_mag;

  // prep register P
  logic                r_p_valid;
  logic [DATA_LEN-1:0] r_p_a;
  logic [DATA_LEN-1:0] r_p_b;
  logic                r_p_qneg;
  logic                r_p_rneg;
  logic                r_p_dz;
  logic                r_p_ov;
  logic [TAG_W-1:0]    r_p_tag;

  // iteration registers S1..S_STAGES (index 0 is S1)
  logic [STAGES-1:0]   r_s_valid;
  logic [STAGES-1:0]   r_s_qneg;
  logic [STAGES-1:0]   r_s_rneg;
  logic [STAGES-1:0]   r_s_dz;
  logic [STAGES-1:0]   r_s_ov;
  logic [DATA_LEN-1:0] r_s_rem [STAGES];
  logic [DATA_LEN-1:0] r_s_q   [STAGES];
  logic [DATA_LEN-1:0] r_s_b   [STAGES];
  logic [TAG_W-1:0]    r_s_tag [STAGES];

  // source of each iteration stage and its computed next state
  logic [STAGES-1:0]   w_in_valid;
  logic [STAGES-1:0]   w_in_qneg;
  logic [STAGES-1:0]   w_in_rneg;
  logic [STAGES-1:0]   w_in_dz;
  logic [STAGES-1:0]   w_in_ov;
  logic [DATA_LEN-1:0] w_in_rem  [STAGES];
  logic [DATA_LEN-1:0] w_in_q    [STAGES];
  logic [DATA_LEN-1:0] w_in_b    [STAGES];
  logic [TAG_W-1:0]    w_in_tag  [STAGES];
  logic [DATA_LEN-1:0] w_nxt_rem [STAGES];
  logic [DATA_LEN-1:0] w_nxt_q   [STAGES];
  logic [DATA_LEN:0]   w_step_rem;
  logic [DATA_LEN-1:0] w_step_q;

  // output register O
  logic                r_o_valid;
  logic [DATA_LEN-1:0] r_o_quot;
  logic [DATA_LEN-1:0] r_o_rem;
  logic [TAG_W-1:0]    r_o_tag;
  logic                r_o_dz;
  logic                r_o_ov;

  logic [DATA_LEN-1:0] w_q_fix;
  logic [DATA_LEN-1:0] w_r_fix;

  // Whole pipeline advances together; a held result freezes every stage, bubbles included.
  assign w_en       = !r_o_valid || i_out_ready;
  assign o_in_ready = w_en;

  assign w_a_neg = i_in_signed & i_in_a[DATA_LEN-1];
  assign w_b_neg = i_in_signed & i_in_b[DATA_LEN-1];
  assign w_a_mag = w_a_neg ? -i_in_a : i_in_a;
  assign w_b_mag = w_b_neg ? -i_in_b : i_in_b;

  // Route stage sources: P feeds S1, each S feeds the next one.
  always_comb begin
    w_in_valid  = '0;
    w_in_qneg   = '0;
    w_in_rneg   = '0;
    w_in_dz     = '0;
    w_in_ov     = '0;
    w_in_valid[0] = r_p_valid;
    w_in_qneg[0]  = r_p_qneg;
    w_in_rneg[0]  = r_p_rneg;
    w_in_dz[0]    = r_p_dz;
    w_in_ov[0]    = r_p_ov;
    w_in_rem[0]   = '0;
    w_in_q[0]     = r_p_a;
    w_in_b[0]     = r_p_b;
    w_in_tag[0]   = r_p_tag;
    for (int s = 1; s < STAGES; s++) begin
      w_in_valid[s] = r_s_valid[s-1];
      w_in_qneg[s]  = r_s_qneg[s-1];
      w_in_rneg[s]  = r_s_rneg[s-1];
      w_in_dz[s]    = r_s_dz[s-1];
      w_in_ov[s]    = r_s_ov[s-1];
      w_in_rem[s]   = r_s_rem[s-1];
      w_in_q[s]     = r_s_q[s-1];
      w_in_b[s]     = r_s_b[s-1];
      w_in_tag[s]   = r_s_tag[s-1];
    end
  end

  // Restoring steps per stage; dividend bits shift out of q while quotient bits shift in.
  always_comb begin
    w_step_rem = '0;
    w_step_q   = '0;
    for (int s = 0; s < STAGES; s++) begin
      w_step_rem = {1'b0, w_in_rem[s]};
      w_step_q   = w_in_q[s];
      for (int k = 0; k < STEPS; k++) begin
        w_step_rem = {w_step_rem[DATA_LEN-1:0], w_step_q[DATA_LEN-1]};
        w_step_q   = {w_step_q[DATA_LEN-2:0], 1'b0};
        if (w_step_rem >= {1'b0, w_in_b[s]}) begin
          w_step_rem  = w_step_rem - {1'b0, w_in_b[s]};
          w_step_q[0] = 1'b1;
        end
      end
      w_nxt_rem[s] = w_step_rem[DATA_LEN-1:0];
      w_nxt_q[s]   = w_step_q;
    end
  end

  // Sign correction. For b == 0 the datapath leaves rem = |a|, so the corrected remainder is a itself.
  assign w_q_fix = r_s_qneg[LAST] ? -r_s_q[LAST] : r_s_q[LAST];
  assign w_r_fix = r_s_rneg[LAST] ? -r_s_rem[LAST] : r_s_rem[LAST];

  // Pipeline registers: capture at P, iterate through S, resolve specials in O.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_p_valid <= 1'b0;
      r_s_valid <= '0;
      r_o_valid <= 1'b0;
      r_o_quot  <= '0;
      r_o_rem   <= '0;
      r_o_tag   <= '0;
      r_o_dz    <= 1'b0;
      r_o_ov    <= 1'b0;
    end else if (w_en) begin
      r_p_valid <= i_in_valid;
      if (i_in_valid) begin
        r_p_a    <= w_a_mag;
        r_p_b    <= w_b_mag;
        r_p_qneg <= w_a_neg ^ w_b_neg;
        r_p_rneg <= w_a_neg;
        r_p_dz   <= (i_in_b == '0);
        r_p_ov   <= i_in_signed && (i_in_a == MIN_VAL) && (i_in_b == '1);
        r_p_tag  <= i_in_tag;
      end
      for (int s = 0; s < STAGES; s++) begin
        r_s_valid[s] <= w_in_valid[s];
        r_s_qneg[s]  <= w_in_qneg[s];
        r_s_rneg[s]  <= w_in_rneg[s];
        r_s_dz[s]    <= w_in_dz[s];
        r_s_ov[s]    <= w_in_ov[s];
        r_s_rem[s]   <= w_nxt_rem[s];
        r_s_q[s]     <= w_nxt_q[s];
        r_s_b[s]     <= w_in_b[s];
        r_s_tag[s]   <= w_in_tag[s];
      end
      r_o_valid <= r_s_valid[LAST];
      if (r_s_valid[LAST]) begin
        r_o_tag <= r_s_tag[LAST];
        r_o_dz  <= r_s_dz[LAST];
        r_o_ov  <= r_s_ov[LAST] && !r_s_dz[LAST];
        if (r_s_dz[LAST]) begin
          r_o_quot <= '1;
          r_o_rem  <= w_r_fix;
        end else if (r_s_ov[LAST]) begin
          r_o_quot <= MIN_VAL;
          r_o_rem  <= '0;
        end else begin
          r_o_quot <= w_q_fix;
          r_o_rem  <= w_r_fix;
        end
      end
    end
  end

  assign o_out_valid    = r_o_valid;
  assign o_out_quot     = r_o_quot;
  assign o_out_rem      = r_o_rem;
  assign o_out_tag      = r_o_tag;
  assign o_out_div_zero = r_o_dz;
  assign o_out_overflow = r_o_ov;
  assign o_busy         = r_p_valid | (|r_s_valid) | r_o_valid;

endmodule

// File: tb/tb_divider_stream.sv
// tb/tb_divider_stream.sv - self-checking bench for divider_stream
module tb_divider_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_signed;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_quot;
  logic [31:0] out_rem;
  logic [7:0]  out_tag;
  logic        out_div_zero;
  logic        out_overflow;
  logic        busy;

  typedef struct packed {
    logic [31:0] quot;
    logic [31:0] rem;
    logic [7:0]  tag;
    logic        dz;
    logic        ov;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  divider_stream #(.DATA_LEN(32), .STAGES(8), .TAG_W(8)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_in_a         (in_a),
    .i_in_b         (in_b),
    .i_in_signed    (in_signed),
    .i_in_tag       (in_tag),
    .o_out_valid    (out_valid),
    .i_out_ready    (out_ready),
    .o_out_quot     (out_quot),
    .o_out_rem      (out_rem),
    .o_out_tag      (out_tag),
    .o_out_div_zero (out_div_zero),
    .o_out_overflow (out_overflow),
    .o_busy         (busy)
  );

  function automatic exp_t ref_div(logic [31:0] a, logic [31:0] b, logic sgn, logic [7:0] tag);
    exp_t e;
    e.tag = tag;
    e.dz  = 1'b0;
    e.ov  = 1'b0;
    if (b == 32'd0) begin
      e.quot = 32'hFFFFFFFF;
      e.rem  = a;
      e.dz   = 1'b1;
    end else if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      e.quot = 32'h80000000;
      e.rem  = 32'd0;
      e.ov   = 1'b1;
    end else if (sgn) begin
      e.quot = $signed(a) / $signed(b);
      e.rem  = $signed(a) % $signed(b);
    end else begin
      e.quot = a / b;
      e.rem  = a % b;
    end
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_tests++;
    if ({out_quot, out_rem, out_tag, out_div_zero, out_overflow} !== 74'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got q=%h r=%h t=%h dz=%b ov=%b want all 0", out_quot, out_rem, out_tag, out_div_zero, out_overflow);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [9];
    logic [31:0] tb [9];
    logic        ts [9];
    logic [31:0] tq [9];
    logic [31:0] tr [9];
    logic        tz [9];
    logic        to [9];
    exp_t e, got;
    int lat;
    ta = '{32'd100, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9, 32'd5, 32'hFFFFFFFB, 32'h80000000, 32'h80000000};
    tb = '{32'd7, 32'd1, 32'd2, 32'hFFFFFFFE, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    ts = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tq = '{32'd14, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h7FFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    tr = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd5, 32'hFFFFFFFB, 32'd0, 32'h80000000};
    tz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    to = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    sb_q.delete();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1;
      in_a = ta[i]; in_b = tb[i]; in_signed = ts[i]; in_tag = 8'h11 + 8'(i);
      sb_q.push_back('{quot: tq[i], rem: tr[i], tag: 8'h11 + 8'(i), dz: tz[i], ov: to[i]});
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 30) begin
        @(negedge clk);
        lat++;
      end
      n_tests++;
      if (lat !== 10) begin n_fail++; $display("FAIL dir_latency[%0d] got %0d want 10", i, lat); end
      n_tests++;
      if (!out_valid || sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL dir_result[%0d] got no output want one result", i);
        sb_q.delete();
      end else begin
        e   = sb_q.pop_front();
        got = {out_quot, out_rem, out_tag, out_div_zero, out_overflow};
        if (got !== e) begin
          n_fail++;
          $display("FAIL dir_result[%0d] got q=%h r=%h t=%h dz=%b ov=%b want q=%h r=%h t=%h dz=%b ov=%b",
                   i, got.quot, got.rem, got.tag, got.dz, got.ov, e.quot, e.rem, e.tag, e.dz, e.ov);
        end
      end
    end
  endtask

  task automatic test_streaming();
    int   sent = 0, got_n = 0, cyc = 0, mode;
    logic prev_stall = 1'b0;
    exp_t held, e, got;
    sb_q.delete();
    in_valid = 1'b0;
    while (got_n < 200 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 99) < 50);
      in_valid  = (sent < 200) && ($urandom_range(0, 99) < 70);
      mode      = $urandom_range(0, 9);
      in_a      = $urandom;
      in_b      = $urandom;
      in_signed = $urandom_range(0, 1);
      if (mode == 0) in_b = 32'd0;
      else if (mode == 1) begin in_a = 32'h80000000; in_b = 32'hFFFFFFFF; end
      else if (mode == 2) in_b = $urandom_range(1, 15);
      in_tag = sent[7:0];
      #1;
      got = {out_quot, out_rem, out_tag, out_div_zero, out_overflow};
      n_tests++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        n_fail++;
        $display("FAIL stream_in_ready cyc %0d got %b want %b", cyc, in_ready, !(out_valid && !out_ready));
      end
      if (prev_stall) begin
        n_tests++;
        if (!out_valid || got !== held) begin
          n_fail++;
          $display("FAIL stream_hold cyc %0d got v=%b %h want v=1 %h", cyc, out_valid, got, held);
        end
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_result cyc %0d got unexpected output want none", cyc);
        end else begin
          e = sb_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL stream_result #%0d got q=%h r=%h t=%h dz=%b ov=%b want q=%h r=%h t=%h dz=%b ov=%b",
                     got_n, got.quot, got.rem, got.tag, got.dz, got.ov, e.quot, e.rem, e.tag, e.dz, e.ov);
          end
        end
        got_n++;
      end
      prev_stall = out_valid && !out_ready;
      held       = got;
      if (in_valid && in_ready) begin
        sb_q.push_back(ref_div(in_a, in_b, in_signed, in_tag));
        sent++;
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (got_n !== 200) begin n_fail++; $display("FAIL stream_count got %0d want 200", got_n); end
  endtask

  task automatic test_back_to_back();
    exp_t e, got;
    int   waitc = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (busy && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    sb_q.delete();
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      got = {out_quot, out_rem, out_tag, out_div_zero, out_overflow};
      n_tests++;
      if (out_valid !== (c >= 10 && c < 60)) begin
        n_fail++;
        $display("FAIL b2b_valid cyc %0d got %b want %b", c, out_valid, (c >= 10 && c < 60));
      end
      if (out_valid) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_result cyc %0d got unexpected output want none", c);
        end else begin
          e = sb_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL b2b_result cyc %0d got %h want %h", c, got, e);
          end
        end
      end
      in_valid  = (c < 50);
      in_a      = $urandom;
      in_b      = $urandom_range(1, 1000);
      in_signed = $urandom_range(0, 1);
      in_tag    = 8'(c);
      #1;
      if (in_valid && in_ready) sb_q.push_back(ref_div(in_a, in_b, in_signed, in_tag));
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midflight();
    int seen = 0, lat;
    exp_t got;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 32'd1000 + 32'(c); in_b = 32'd7; in_signed = 1'b0; in_tag = 8'(c);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_tests++;
    if (seen !== 0) begin n_fail++; $display("FAIL midrst_flushed got %0d outputs want 0", seen); end
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'd9; in_b = 32'd3; in_signed = 1'b0; in_tag = 8'h5A;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    n_tests++;
    if (lat !== 10) begin n_fail++; $display("FAIL midrst_latency got %0d want 10", lat); end
    got = {out_quot, out_rem, out_tag, out_div_zero, out_overflow};
    n_tests++;
    if (!out_valid || got !== {32'd3, 32'd0, 8'h5A, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_result got v=%b q=%h r=%h t=%h want q=3 r=0 t=5a", out_valid, out_quot, out_rem, out_tag);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_streaming();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_stream.md
# divider_stream

Parametrised, fully pipelined integer divider with a valid/ready streaming interface, per-transaction signed/unsigned mode, quotient and remainder outputs, and exception flags. It is the next-generation replacement for the fixed-latency, handshake-free divider behind the AFU test harness. The AFU feeds operand pairs unpacked from host cache lines and collects results in order for write-back, at one division per cycle when the sink does not stall.

## Interface
Parameters:
- DATA_LEN, 32, operand/result width; must be ≥ 2 and divisible by STAGES.
- STAGES, 8, iteration stages; each resolves DATA_LEN/STAGES quotient bits.
- TAG_W, 8, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  divider can accept; a transfer occurs when in_valid && in_ready.
- in_a  in  DATA_LEN  dividend.
- in_b  in  DATA_LEN  divisor.
- in_signed  in  1  1 = two's-complement division, 0 = unsigned.
- in_tag  in  TAG_W  returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts; a transfer occurs when out_valid && out_ready.
- out_quot  out  DATA_LEN  quotient.
- out_rem  out  DATA_LEN  remainder.
- out_tag  out  TAG_W  tag of this result.
- out_div_zero  out  1  divisor was zero.
- out_overflow  out  1  signed MIN / -1.
- busy  out  1  any pipeline register holds a valid operation.

## Operation
- Pipeline: prep register P, iteration registers S1..S_STAGES, output register O. Each register carries a valid bit.
- P captures the magnitudes |a| and |b| (these equal a and b when unsigned), the quotient sign (sa^sb), the remainder sign (sa), the div_zero and overflow flags, and the tag.
- Each S stage performs DATA_LEN/STAGES restoring-division steps. The partial remainder is DATA_LEN+1 bits wide, so there is no overflow at the MSB.
- O applies sign correction: the quotient is negated if the quotient sign is set, and the remainder is negated if the remainder sign is set. The remainder therefore takes the sign of the dividend (truncating division).
- Special cases are resolved in O and override the datapath:
  - b == 0: quot = all ones, rem = a (raw input), div_zero = 1. This holds in both modes.
  - Signed, a == MIN, b == -1: quot = MIN, rem = 0, overflow = 1.
  - The two flags are never set together.
- Stall: en = !out_valid || out_ready. When en = 0, every register holds its value, including bubbles. When en = 1, all registers advance.
- in_ready = en (combinational from out_ready; the path is documented as one combinational hop).
- Results emerge strictly in acceptance order. Bubbles advance and are never emitted.
- busy = OR of all valid bits in P, S1..S_STAGES and O.

## Timing
- Reset: all valid bits clear. out_valid = 0, busy = 0, in_ready = 1 in the first cycle after reset. out_quot, out_rem, out_tag and both flags reset to 0.
- Latency: an input accepted at edge k is presented with out_valid = 1 after edge k+STAGES+1, i.e. STAGES+2 registers. The default is 10 cycles.
- Throughput: 1 operation/cycle with out_ready held high; no bubbles are inserted.
- Holding: while out_valid && !out_ready, out_* stay stable and in_ready = 0.
- Simultaneous out transfer and in transfer in the same cycle is legal and required at full rate.
- Reset mid-operation: all in-flight operations are discarded without being emitted. The next accepted input completes with normal latency.
- in_* are sampled only on a transfer; values are don't-care otherwise.

## Test plan
- Unsigned 100/7, tag 0x11 -> after 10 cycles: quot 14, rem 2, tag 0x11, flags 0. Also 0xFFFFFFFF/1 -> quot 0xFFFFFFFF, rem 0.
- Signed -7/2 -> quot 0xFFFFFFFD, rem 0xFFFFFFFF. Signed 7/-2 -> quot 0xFFFFFFFD, rem 1. Unsigned 0xFFFFFFF9/2 -> quot 0x7FFFFFFC, rem 1.
- Exceptions:
  - 5/0 (unsigned) -> quot 0xFFFFFFFF, rem 5, div_zero 1.
  - Signed -5/0 -> quot 0xFFFFFFFF, rem 0xFFFFFFFB, div_zero 1.
  - Signed 0x80000000/0xFFFFFFFF -> quot 0x80000000, rem 0, overflow 1.
- Streaming: 200 random ops with tags 0..199, in_valid random at 70%, out_ready random at 50%. Every result must match the reference model in order; out_* must be stable during stalls; in_ready must be 0 exactly when out_valid && !out_ready.
- Full rate: 50 back-to-back ops with out_ready = 1 -> 50 consecutive out_valid cycles starting at cycle 10, no gaps.
- Reset: assert reset with 6 ops in flight -> no further out_valid, busy = 0 next cycle. Then 9/3 -> quot 3, rem 0 after 10 cycles.
